// File: rtl/conf_register_bank_pkg.sv
// Shared address-map defaults and width helper for configuration register banks.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package conf_register_bank_pkg;

    // Default address map for a bank instance; each instance may override these.
    localparam logic [15:0] DEF_BASE_ADDR   = 16'h0010;
    localparam logic [15:0] DEF_COMMIT_ADDR = 16'h00FF;

    // Bits needed to index n registers, never less than one so that a
    // single-register bank still has a legal offset vector.
    function automatic int offset_bits(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/conf_reg_cell.sv
// One configuration register: optional shadow stage feeding the active output.
// Latency: active/upd change one cycle after the write (direct) or apply (shadowed) edge.
// Backpressure: none; accepts a write or apply on any cycle.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   wr_en     write strobe for this register (already qualified by decode)
//   wr_dat    write data
//   apply     copy shadow into active this edge (shadowed mode only)
//   active    active register value
//   upd       one-cycle pulse after active is loaded
module conf_reg_cell #(
    parameter int                    DATA_WIDTH  = 16,
    parameter bit                    SHADOWED    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  apply,
    output logic [DATA_WIDTH-1:0] active,
    output logic                  upd
);

    logic [DATA_WIDTH-1:0] shadow;
    logic                  shadow_wr;
    logic                  direct_wr;
    logic                  load;

    assign shadow_wr = SHADOWED && wr_en;
    assign direct_wr = !SHADOWED && wr_en;
    assign load      = apply || direct_wr;

    // In direct mode the shadow never changes and folds to its reset constant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= RESET_VALUE;
        end else if (shadow_wr) begin
            shadow <= wr_dat;
        end
    end

    // apply reads the pre-write shadow: a shadow write on the apply edge is
    // held back for the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= RESET_VALUE;
            upd    <= 1'b0;
        end else begin
            upd <= load;
            if (load) begin
                active <= apply ? shadow : wr_dat;
            end
        end
    end

endmodule

// File: rtl/conf_register_bank.sv
// Bank of NUM_REGS configuration registers on the si_* write bus, optionally double-buffered.
// Latency: si_ack one cycle after capture; regs one cycle after capture (direct) or apply edge (shadowed).
// Backpressure: no capture while si_ack is high (one write per 2 cycles); non-hitting requests are never acked.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   si_addr/si_data  write address and data; si_rdy request, si_ack registered acknowledge
//   apply_en         a pending commit may transfer this cycle
//   regs             active register values, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   upd              bit i pulses the cycle after active register i is loaded
//   commit_pending   commit armed but not yet applied
//   applied          one-cycle pulse after a commit transfer
module conf_register_bank
    import conf_register_bank_pkg::*;
#(
    parameter int                             ADDR_WIDTH   = 16,
    parameter int                             DATA_WIDTH   = 16,
    parameter int                             NUM_REGS     = 8,
    parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR    = DEF_BASE_ADDR,
    parameter logic [ADDR_WIDTH-1:0]          COMMIT_ADDR  = DEF_COMMIT_ADDR,
    parameter bit                             SHADOWED     = 1'b1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          si_addr,
    input  logic [DATA_WIDTH-1:0]          si_data,
    input  logic                           si_rdy,
    output logic                           si_ack,
    input  logic                           apply_en,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]            upd,
    output logic                           commit_pending,
    output logic                           applied
);

    localparam int OFFW = offset_bits(NUM_REGS);

    // Window bounds carried one bit wider so BASE_ADDR+NUM_REGS cannot wrap.
    localparam logic [ADDR_WIDTH:0] WIN_LO     = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI     = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] COMMIT_EXT = {1'b0, COMMIT_ADDR};

    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("conf_register_bank: NUM_REGS must be 1..64");
    end
    if (COMMIT_EXT >= WIN_LO && COMMIT_EXT < WIN_HI) begin : g_bad_commit_addr
        $error("conf_register_bank: COMMIT_ADDR lies inside the register window");
    end

    logic            win_hit;
    logic            commit_hit;
    logic            capture;
    logic            do_apply;
    logic [OFFW-1:0] offset;

    assign win_hit    = ({1'b0, si_addr} >= WIN_LO) && ({1'b0, si_addr} < WIN_HI);
    assign commit_hit = SHADOWED && (si_addr == COMMIT_ADDR);
    assign offset     = OFFW'(si_addr - BASE_ADDR);
    assign capture    = si_rdy && !si_ack && (win_hit || commit_hit);
    // Only a commit armed before this edge can apply; a same-edge arm waits a cycle.
    assign do_apply   = SHADOWED && commit_pending && apply_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            si_ack         <= 1'b0;
            commit_pending <= 1'b0;
            applied        <= 1'b0;
        end else begin
            si_ack  <= capture;
            applied <= do_apply;
            // A commit write on the apply edge re-arms rather than being lost.
            if (capture && commit_hit) begin
                commit_pending <= 1'b1;
            end else if (do_apply) begin
                commit_pending <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        logic cell_wr;
        assign cell_wr = capture && win_hit && (offset == OFFW'(i));

        conf_reg_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHADOWED    (SHADOWED),
            .RESET_VALUE (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (cell_wr),
            .wr_dat (si_data),
            .apply  (do_apply),
            .active (regs[i*DATA_WIDTH +: DATA_WIDTH]),
            .upd    (upd[i])
        );
    end

endmodule

// File: tb/tb_conf_register_bank.sv
// Directed bench for conf_register_bank: one shadowed and one direct-mode instance.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Every check goes through chk(); a single summary line ends the run.
module tb_conf_register_bank;

    localparam logic [127:0] RV = {96'h0, 16'hABCD, 16'h1234};

    logic         clk = 1'b0;
    logic         rst;

    logic [15:0]  s_addr, s_data;
    logic         s_rdy, s_ack, s_apply, s_pend, s_applied;
    logic [127:0] s_regs;
    logic [7:0]   s_upd;

    logic [15:0]  d_addr, d_data;
    logic         d_rdy, d_ack, d_apply, d_pend, d_applied;
    logic [127:0] d_regs;
    logic [7:0]   d_upd;

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] s_exp;
    logic [127:0] d_exp;

    always #5 clk = ~clk;

    conf_register_bank #(
        .SHADOWED     (1'b1),
        .RESET_VALUES (RV)
    ) dut_s (
        .clk            (clk),
        .rst            (rst),
        .si_addr        (s_addr),
        .si_data        (s_data),
        .si_rdy         (s_rdy),
        .si_ack         (s_ack),
        .apply_en       (s_apply),
        .regs           (s_regs),
        .upd            (s_upd),
        .commit_pending (s_pend),
        .applied        (s_applied)
    );

    conf_register_bank #(
        .SHADOWED     (1'b0),
        .RESET_VALUES (RV)
    ) dut_d (
        .clk            (clk),
        .rst            (rst),
        .si_addr        (d_addr),
        .si_data        (d_data),
        .si_rdy         (d_rdy),
        .si_ack         (d_ack),
        .apply_en       (d_apply),
        .regs           (d_regs),
        .upd            (d_upd),
        .commit_pending (d_pend),
        .applied        (d_applied)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full handshake on the shadowed instance: ack for exactly one cycle.
    task automatic s_write(input logic [15:0] a, input logic [15:0] d);
        s_addr = a;
        s_data = d;
        s_rdy  = 1'b1;
        step();
        chk("s_ack_hi", s_ack, 1);
        s_rdy = 1'b0;
        step();
        chk("s_ack_lo", s_ack, 0);
    endtask

    initial begin
        rst = 1'b1;
        s_addr = '0; s_data = '0; s_rdy = 1'b0; s_apply = 1'b0;
        d_addr = '0; d_data = '0; d_rdy = 1'b0; d_apply = 1'b0;
        s_exp = RV;
        d_exp = RV;

        // Reset state
        #3;
        chk("rst_s_regs", s_regs, RV);
        chk("rst_d_regs", d_regs, RV);
        chk("rst_s_ack", s_ack, 0);
        chk("rst_s_pend", s_pend, 0);
        chk("rst_s_upd", s_upd, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_regs", s_regs, RV);

        // Shadow writes do not reach regs until a commit is applied
        s_write(16'h0012, 16'h00AA);
        chk("shadow_no_change_a", s_regs, s_exp);
        s_write(16'h0017, 16'h0055);
        chk("shadow_no_change_b", s_regs, s_exp);
        s_write(16'h00FF, 16'h0000);
        chk("commit_armed", s_pend, 1);
        for (int i = 0; i < 5; i++) step();
        chk("apply_held_regs", s_regs, s_exp);
        chk("apply_held_pend", s_pend, 1);
        s_apply = 1'b1;
        step();
        s_exp[2*16 +: 16] = 16'h00AA;
        s_exp[7*16 +: 16] = 16'h0055;
        chk("apply_regs", s_regs, s_exp);
        chk("apply_applied", s_applied, 1);
        chk("apply_upd", s_upd, 8'hFF);
        chk("apply_pend_clr", s_pend, 0);
        s_apply = 1'b0;
        step();
        chk("applied_pulse_end", s_applied, 0);
        chk("upd_pulse_end", s_upd, 0);

        // Addresses just outside the window are never acknowledged
        s_data = 16'hDEAD;
        s_addr = 16'h0018;
        s_rdy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("miss_hi_ack", s_ack, 0);
        end
        s_addr = 16'h000F;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("miss_lo_ack", s_ack, 0);
        end
        s_rdy = 1'b0;
        step();
        chk("miss_regs", s_regs, s_exp);
        chk("miss_pend", s_pend, 0);

        // Commit write on the apply edge re-arms the commit
        s_write(16'h00FF, 16'h0000);
        s_addr  = 16'h00FF;
        s_rdy   = 1'b1;
        s_apply = 1'b1;
        step();
        chk("rearm_applied", s_applied, 1);
        chk("rearm_pend", s_pend, 1);
        chk("rearm_ack", s_ack, 1);
        s_rdy   = 1'b0;
        s_apply = 1'b0;
        step();
        s_apply = 1'b1;
        step();
        chk("rearm_second_apply", s_applied, 1);
        chk("rearm_pend_clr", s_pend, 0);
        s_apply = 1'b0;
        step();

        // Shadow write on the apply edge: active takes the old shadow value
        s_write(16'h0010, 16'h1111);
        s_write(16'h00FF, 16'h0000);
        s_addr  = 16'h0010;
        s_data  = 16'h0F0F;
        s_rdy   = 1'b1;
        s_apply = 1'b1;
        step();
        s_exp[0 +: 16] = 16'h1111;
        chk("coinc_regs", s_regs, s_exp);
        chk("coinc_pend", s_pend, 0);
        chk("coinc_ack", s_ack, 1);
        s_rdy   = 1'b0;
        s_apply = 1'b0;
        step();

        // Commit captured with apply_en already high applies one edge later
        s_addr  = 16'h00FF;
        s_rdy   = 1'b1;
        s_apply = 1'b1;
        step();
        chk("late_apply_applied", s_applied, 0);
        chk("late_apply_pend", s_pend, 1);
        chk("late_apply_regs", s_regs, s_exp);
        s_rdy = 1'b0;
        step();
        s_exp[0 +: 16] = 16'h0F0F;
        chk("late_apply_done", s_applied, 1);
        chk("late_apply_regs2", s_regs, s_exp);
        s_apply = 1'b0;
        step();

        // Direct mode: write lands in regs one cycle after capture
        d_addr = 16'h0013;
        d_data = 16'hBEEF;
        d_rdy  = 1'b1;
        step();
        d_exp[3*16 +: 16] = 16'hBEEF;
        chk("direct_regs", d_regs, d_exp);
        chk("direct_upd", d_upd, 8'h08);
        chk("direct_ack", d_ack, 1);
        d_rdy = 1'b0;
        step();
        chk("direct_upd_end", d_upd, 0);
        chk("direct_ack_end", d_ack, 0);
        d_addr = 16'h00FF;
        d_rdy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("direct_commit_noack", d_ack, 0);
        end
        chk("direct_pend", d_pend, 0);
        d_rdy = 1'b0;
        step();

        // Asynchronous reset in the middle of an ack with a commit pending
        s_write(16'h0011, 16'h7777);
        s_addr = 16'h00FF;
        s_rdy  = 1'b1;
        d_addr = 16'h0014;
        d_data = 16'h4242;
        d_rdy  = 1'b1;
        step();
        chk("pre_rst_ack", s_ack, 1);
        chk("pre_rst_pend", s_pend, 1);
        chk("pre_rst_d_upd", d_upd, 8'h10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s_ack", s_ack, 0);
        chk("arst_s_pend", s_pend, 0);
        chk("arst_s_upd", s_upd, 0);
        chk("arst_s_regs", s_regs, RV);
        chk("arst_d_ack", d_ack, 0);
        chk("arst_d_upd", d_upd, 0);
        chk("arst_d_regs", d_regs, RV);
        s_rdy = 1'b0;
        d_rdy = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("after_rst_regs", s_regs, RV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
